// File: rtl/azadi_prog_pkg.sv
// Shared register map, bit positions and TX state type for the programming UART.
package azadi_prog_pkg;

  localparam int unsigned ByteW = 8;
  localparam int unsigned CpbW  = 16;

  // Word index taken from wbs_adr_i[3:2]
  localparam logic [1:0] RegData   = 2'd0;
  localparam logic [1:0] RegCtrl   = 2'd1;
  localparam logic [1:0] RegStatus = 2'd2;
  localparam logic [1:0] RegRsvd   = 2'd3;

  localparam int unsigned CtrlCpbLsb    = 0;
  localparam int unsigned CtrlProgEnBit = 16;
  localparam int unsigned CtrlIrqEnBit  = 17;

  localparam int unsigned StatBusyBit  = 0;
  localparam int unsigned StatFullBit  = 1;
  localparam int unsigned StatEmptyBit = 2;
  localparam int unsigned StatOvfBit   = 3;
  localparam int unsigned StatCountLsb = 8;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StData  = 2'd2,
    StStop  = 2'd3
  } tx_state_e;

  function automatic logic [31:0] pack_ctrl(input logic [CpbW-1:0] cpb, input logic prog_en,
                                            input logic irq_en);
    logic [31:0] w;
    w = '0;
    w[CtrlCpbLsb +: CpbW] = cpb;
    w[CtrlProgEnBit]      = prog_en;
    w[CtrlIrqEnBit]       = irq_en;
    return w;
  endfunction

  function automatic logic [31:0] pack_status(input logic busy, input logic full,
                                              input logic empty, input logic ovf,
                                              input logic [7:0] count);
    logic [31:0] w;
    w = '0;
    w[StatBusyBit]         = busy;
    w[StatFullBit]         = full;
    w[StatEmptyBit]        = empty;
    w[StatOvfBit]          = ovf;
    w[StatCountLsb +: 8]   = count;
    return w;
  endfunction

endpackage

// File: rtl/prog_fifo.sv
// Synchronous byte FIFO with occupancy count; a push into a full FIFO is accepted
// only when a pop happens in the same cycle.
module prog_fifo
  import azadi_prog_pkg::*;
#(
  parameter int unsigned Depth = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [ByteW-1:0]         push_data,
  input  logic                     pop,
  output logic [ByteW-1:0]         pop_data,
  output logic [$clog2(Depth):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AddrW = $clog2(Depth);
  localparam int unsigned CntW  = AddrW + 1;

  logic [ByteW-1:0] mem [Depth];
  logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  cnt_q;
  logic             do_push, do_pop;

  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == CntW'(Depth));
  assign count    = cnt_q;
  assign pop_data = mem[rd_ptr_q];
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);

  // Storage array; no reset needed, occupancy is tracked by the counter.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q] <= push_data;
    end
  end

  // Pointers wrap naturally because Depth is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AddrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AddrW'(1);
      if (do_push && !do_pop) begin
        cnt_q <= cnt_q + CntW'(1);
      end else if (do_pop && !do_push) begin
        cnt_q <= cnt_q - CntW'(1);
      end
    end
  end

endmodule

// File: rtl/wb_uart_prog_tx.sv
// Wishbone-attached 8N1 transmitter that streams a programming image to the SoC
// boot receiver; bytes are queued in a FIFO and sent back-to-back.
module wb_uart_prog_tx
  import azadi_prog_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        uart_tx_o,
  output logic        prog_o,
  output logic        irq_o
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  // Bus interface
  logic        ack_q, blocked_q;
  logic [31:0] rdata_q, rdata;
  logic        req, wr, rd;
  logic [1:0]  reg_idx;

  // Registers
  logic [CpbW-1:0] ctrl_cpb;
  logic            ctrl_prog_en, ctrl_irq_en;
  logic            ovf_q;

  // FIFO
  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [ByteW-1:0] fifo_data;
  logic [CntW-1:0]  fifo_count;

  // Serializer
  tx_state_e       state_q, state_d;
  logic [CpbW-1:0] bit_cnt_q, bit_cnt_d;
  logic [CpbW-1:0] cpb_lat_q, cpb_lat_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic            start_ok;

  logic unused_bits;
  assign unused_bits = ^{wbs_dat_i[31:18], wbs_adr_i[31:4], wbs_adr_i[1:0], wbs_sel_i[3]};

  // blocked_q holds off a second ack until the master drops stb/cyc; it powers
  // up set so an access in flight across reset is never acknowledged.
  assign req     = wbs_stb_i & wbs_cyc_i & ~ack_q & ~blocked_q;
  assign wr      = req & wbs_we_i;
  assign rd      = req & ~wbs_we_i;
  assign reg_idx = wbs_adr_i[3:2];

  assign fifo_push = wr & (reg_idx == RegData) & wbs_sel_i[0];

  // Read data mux, sampled into rdata_q on the ack edge.
  always_comb begin
    rdata = '0;
    case (reg_idx)
      RegCtrl:   rdata = pack_ctrl(ctrl_cpb, ctrl_prog_en, ctrl_irq_en);
      RegStatus: rdata = pack_status(state_q != StIdle, fifo_full, fifo_empty, ovf_q,
                                     8'(fifo_count));
      RegData,
      RegRsvd:   rdata = '0;
      default:   rdata = '0;
    endcase
  end

  // Single-cycle ack and read data that is zero outside the ack cycle.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ack_q     <= 1'b0;
      blocked_q <= 1'b1;
      rdata_q   <= '0;
    end else begin
      ack_q     <= req;
      blocked_q <= wbs_stb_i & wbs_cyc_i & (ack_q | blocked_q);
      rdata_q   <= rd ? rdata : '0;
    end
  end

  // CTRL register, byte-lane masked.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ctrl_cpb     <= '0;
      ctrl_prog_en <= 1'b0;
      ctrl_irq_en  <= 1'b0;
    end else if (wr && reg_idx == RegCtrl) begin
      if (wbs_sel_i[0]) ctrl_cpb[7:0]  <= wbs_dat_i[7:0];
      if (wbs_sel_i[1]) ctrl_cpb[15:8] <= wbs_dat_i[15:8];
      if (wbs_sel_i[2]) begin
        ctrl_prog_en <= wbs_dat_i[CtrlProgEnBit];
        ctrl_irq_en  <= wbs_dat_i[CtrlIrqEnBit];
      end
    end
  end

  // Sticky overflow: set when a push is dropped, cleared by W1C on STATUS.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ovf_q <= 1'b0;
    end else if (wr && reg_idx == RegStatus && wbs_sel_i[0] && wbs_dat_i[StatOvfBit]) begin
      ovf_q <= 1'b0;
    end else if (fifo_push && fifo_full && !fifo_pop) begin
      ovf_q <= 1'b1;
    end
  end

  prog_fifo #(
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk       (wb_clk_i),
    .rst       (wb_rst_i),
    .push      (fifo_push),
    .push_data (wbs_dat_i[7:0]),
    .pop       (fifo_pop),
    .pop_data  (fifo_data),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign start_ok = ~fifo_empty & (ctrl_cpb >= 16'd2);

  // Serializer next state; bit_cnt counts down the remaining cycles of the current bit.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    cpb_lat_d = cpb_lat_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    fifo_pop  = 1'b0;
    unique case (state_q)
      StIdle: begin
        tx_d = 1'b1;
        if (start_ok) begin
          fifo_pop  = 1'b1;
          cpb_lat_d = ctrl_cpb;
          bit_cnt_d = ctrl_cpb - 16'd1;
          shift_d   = fifo_data;
          tx_d      = 1'b0;
          state_d   = StStart;
        end
      end
      StStart: begin
        if (bit_cnt_q == '0) begin
          bit_cnt_d = cpb_lat_q - 16'd1;
          bit_idx_d = 3'd0;
          tx_d      = shift_q[0];
          shift_d   = shift_q >> 1;
          state_d   = StData;
        end else begin
          bit_cnt_d = bit_cnt_q - 16'd1;
        end
      end
      StData: begin
        if (bit_cnt_q == '0) begin
          bit_cnt_d = cpb_lat_q - 16'd1;
          if (bit_idx_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = StStop;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = shift_q[0];
            shift_d   = shift_q >> 1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q - 16'd1;
        end
      end
      StStop: begin
        if (bit_cnt_q == '0) begin
          if (start_ok) begin
            // Chain straight into the next start bit with no idle cycle.
            fifo_pop  = 1'b1;
            cpb_lat_d = ctrl_cpb;
            bit_cnt_d = ctrl_cpb - 16'd1;
            shift_d   = fifo_data;
            tx_d      = 1'b0;
            state_d   = StStart;
          end else begin
            tx_d    = 1'b1;
            state_d = StIdle;
          end
        end else begin
          bit_cnt_d = bit_cnt_q - 16'd1;
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = StIdle;
      end
    endcase
  end

  // Serializer state; the line is registered so it never glitches.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      cpb_lat_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      cpb_lat_q <= cpb_lat_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = rdata_q;
  assign uart_tx_o = tx_q;
  assign prog_o    = ctrl_prog_en;
  assign irq_o     = ctrl_irq_en & fifo_empty & (state_q == StIdle);

endmodule

// File: doc/wb_uart_prog_tx.md
WB_UART_PROG_TX -- requirements
Module: wb_uart_prog_tx

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, SHALL set byte-FIFO depth (power of two, 2..64).
REQ-002 wb_clk_i  in  1  sole clock; all logic SHALL be clocked on its rising edge.
REQ-003 wb_rst_i  in  1  reset, asynchronous, active-high.
REQ-004 wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1 each  Wishbone classic strobe/cycle/write.
REQ-005 wbs_sel_i  in  4  byte lanes; wbs_adr_i  in  32  byte address (bits [3:2] decoded); wbs_dat_i  in  32  write data.
REQ-006 wbs_ack_o  out  1  ack; wbs_dat_o  out  32  read data.
REQ-007 uart_tx_o  out  1  serial line to the SoC programming receiver, 8N1, idle high.
REQ-008 prog_o  out  1  programming-mode request to the SoC.
REQ-009 irq_o  out  1  level interrupt: transfer drained.

Function
REQ-010 Register map SHALL be: 0x0 DATA (WO), 0x4 CTRL (RW), 0x8 STATUS (RO/W1C), 0xC reserved (reads 0, writes ignored).
REQ-011 CTRL SHALL hold [15:0] clks_per_bit, [16] prog_en, [17] irq_en; bits [31:18] read 0; each byte lane written only when its sel bit is set.
REQ-012 STATUS SHALL read [0] busy (FSM not IDLE), [1] full, [2] empty, [3] overflow (sticky), [15:8] FIFO count; writing 1 to bit 3 with sel[0] SHALL clear overflow.
REQ-013 Write to DATA with sel[0]=1 SHALL push wbs_dat_i[7:0]; sel[0]=0 SHALL push nothing.
REQ-014 Push while full SHALL drop the byte and set overflow; FIFO contents unchanged.
REQ-015 Each access with stb&cyc SHALL receive exactly one single-cycle ack, asserted the cycle after stb&cyc is first sampled; ack SHALL deassert the following cycle even if stb stays high, and a new access SHALL start only after ack has deasserted.
REQ-016 wbs_dat_o SHALL be valid while ack is high and 0 otherwise; writes SHALL take effect on the ack cycle.
REQ-017 prog_o SHALL equal CTRL.prog_en.
REQ-018 TX FSM states: IDLE, START, DATA, STOP.
REQ-019 IDLE -> START when FIFO not empty and clks_per_bit >= 2; byte popped and clks_per_bit latched in the same cycle.
REQ-020 START drives 0, DATA drives 8 bits LSB first, STOP drives 1; each bit SHALL last exactly latched clks_per_bit cycles.
REQ-021 STOP -> START directly, with no idle gap, if FIFO is non-empty and clks_per_bit >= 2 at STOP end; else -> IDLE.
REQ-022 CTRL writes during a frame SHALL NOT affect that frame.
REQ-023 clks_per_bit < 2 SHALL hold FSM in IDLE; FIFO retained.
REQ-024 Simultaneous push and pop SHALL leave count unchanged; push when full with simultaneous pop SHALL be accepted.
REQ-025 irq_o SHALL equal irq_en & empty & IDLE.
REQ-026 Bit-period counter SHALL be 16 bits; uart_tx_o SHALL be registered (glitch-free).

Reset
REQ-027 On wb_rst_i: FIFO empty, overflow 0, CTRL 0, FSM IDLE, wbs_ack_o 0, wbs_dat_o 0, uart_tx_o 1, prog_o 0, irq_o 0.
REQ-028 Reset mid-frame SHALL immediately abort the frame and drive uart_tx_o high; in-flight Wishbone access SHALL not be acked.

Structure
REQ-029 Package azadi_prog_pkg SHALL hold register offsets, CTRL/STATUS bit positions and the TX state enum.
REQ-030 FIFO SHALL be sub-module prog_fifo (sync, count/full/empty outputs); serializer stays in wb_uart_prog_tx.

Verification
REQ-031 CTRL=0x0001_0004, write DATA 0xA5 -> prog_o=1; uart_tx_o: 0, then 1,0,1,0,0,1,0,1, then 1, each 4 cycles; 40 cycles total; then irq_o stays 0 (irq_en=0).
REQ-032 clks_per_bit=0, push 9 bytes (depth 8) -> STATUS=0x0000_080A (count 8, full, overflow); write 0x8 to STATUS -> overflow 0.
REQ-033 clks_per_bit=3, push 0x00,0xFF back-to-back -> frames contiguous, 60 cycles, no idle gap; irq_en=1 -> irq_o rises after the second stop bit.
REQ-034 Hold stb&cyc high 5 cycles on a read of CTRL -> exactly one ack pulse, data 0x0002_0003 when CTRL=0x0002_0003.
REQ-035 Assert wb_rst_i during DATA bit 3 -> uart_tx_o=1 same cycle, STATUS reads 0x0000_0004 after release.
REQ-036 Write CTRL clks_per_bit 4->8 mid-frame -> current frame completes at 4 cycles/bit, next frame at 8.
